// File: rtl/riscv_pkg.sv
// Shared encodings and pipeline-register layouts for the riscv_cpu pipeline.
package riscv_pkg;

    localparam logic [6:0]  OP_RTYPE  = 7'b0110011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_fn_e;

    typedef struct packed {
        alu_fn_e     alu_fn;
        logic        use_imm;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        branch;
        logic        use_rs1;
        logic        use_rs2;
        logic [31:0] imm;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        ctrl_t       ctrl;
    } idex_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } exmem_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_we;
    } memwb_t;

    localparam ctrl_t CTRL_NOP = '{alu_fn: ALU_ADD, use_imm: 1'b0, reg_we: 1'b0,
                                   mem_re: 1'b0, mem_we: 1'b0, branch: 1'b0,
                                   use_rs1: 1'b0, use_rs2: 1'b0, imm: 32'd0};

    localparam ifid_t IFID_RST = '{pc: 32'd0, instr: NOP_INSTR};

    localparam idex_t IDEX_RST = '{pc: 32'd0, instr: NOP_INSTR, rs1_val: 32'd0,
                                   rs2_val: 32'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
                                   ctrl: CTRL_NOP};

    localparam exmem_t EXMEM_RST = '{instr: NOP_INSTR, alu_res: 32'd0, store_val: 32'd0,
                                     rd: 5'd0, reg_we: 1'b0, mem_re: 1'b0, mem_we: 1'b0};

    localparam memwb_t MEMWB_RST = '{instr: NOP_INSTR, wb_val: 32'd0, rd: 5'd0, reg_we: 1'b0};

    // Anything outside the supported subset decodes to CTRL_NOP: no writes, no branch.
    function automatic ctrl_t decode(input logic [31:0] ins);
        ctrl_t      c;
        logic [2:0] f3;
        logic [6:0] f7;
        c  = CTRL_NOP;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            OP_RTYPE: begin
                c.reg_we = 1'b1;
                if (f3 == 3'b000 && f7 == 7'b0000000)      c.alu_fn = ALU_ADD;
                else if (f3 == 3'b000 && f7 == 7'b0100000) c.alu_fn = ALU_SUB;
                else if (f3 == 3'b111 && f7 == 7'b0000000) c.alu_fn = ALU_AND;
                else if (f3 == 3'b110 && f7 == 7'b0000000) c.alu_fn = ALU_OR;
                else                                       c.reg_we = 1'b0;
                c.use_rs1 = c.reg_we;
                c.use_rs2 = c.reg_we;
            end
            OP_IMM: if (f3 == 3'b000) begin
                c.reg_we  = 1'b1;
                c.use_imm = 1'b1;
                c.use_rs1 = 1'b1;
                c.imm     = {{20{ins[31]}}, ins[31:20]};
            end
            OP_LOAD: if (f3 == 3'b010) begin
                c.reg_we  = 1'b1;
                c.mem_re  = 1'b1;
                c.use_imm = 1'b1;
                c.use_rs1 = 1'b1;
                c.imm     = {{20{ins[31]}}, ins[31:20]};
            end
            OP_STORE: if (f3 == 3'b010) begin
                c.mem_we  = 1'b1;
                c.use_imm = 1'b1;
                c.use_rs1 = 1'b1;
                c.use_rs2 = 1'b1;
                c.imm     = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            OP_BRANCH: if (f3 == 3'b000) begin
                c.branch  = 1'b1;
                c.alu_fn  = ALU_SUB;
                c.use_rs1 = 1'b1;
                c.use_rs2 = 1'b1;
                c.imm     = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/riscv_alu.sv
// Combinational 32-bit ALU; zero flag feeds the BEQ decision.
module riscv_alu
    import riscv_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  fn,
    output logic [31:0] y,
    output logic        zero
);

    always_comb begin
        y = a + b;
        case (fn)
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            default: y = a + b;
        endcase
    end

    assign zero = (y == 32'd0);

endmodule

// File: rtl/riscv_cpu.sv
// riscv_cpu: classic 5-stage in-order RV32I-subset pipeline with internal
// memories, full EX forwarding, load-use stall and EX-resolved BEQ.
module riscv_cpu
    import riscv_pkg::*;
#(
    parameter int IMEM_WORDS = 1024,
    parameter int DMEM_WORDS = 1024
) (
    input logic clock,
    input logic reset
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);
    localparam logic [31:0] NOP = NOP_INSTR;

    // Instruction memory is only loaded from outside the design; powers up as NOPs.
    logic [31:0] IMemory [IMEM_WORDS] = '{default: NOP_INSTR};
    logic [31:0] DMemory [DMEM_WORDS];
    logic [31:0] Regs    [32];

    // Initialisers make the pipeline start clean even if reset is never applied.
    logic [31:0] pc_q    = 32'd0;
    ifid_t       ifid_q  = IFID_RST;
    idex_t       idex_q  = IDEX_RST;
    exmem_t      exmem_q = EXMEM_RST;
    memwb_t      memwb_q = MEMWB_RST;

    logic [31:0] pc_d;
    ifid_t       ifid_d;
    idex_t       idex_d;
    exmem_t      exmem_d;
    memwb_t      memwb_d;

    ctrl_t       id_ctrl;
    logic [4:0]  id_rs1, id_rs2;
    logic [31:0] id_rs1_val, id_rs2_val;
    logic        stall;
    logic [31:0] ex_a, ex_b, ex_b_alu, ex_res, ex_target;
    logic        ex_zero, take_branch;
    logic [31:0] mem_rdata, mem_wb_val;
    logic        unused_bits;

    // ID: decode, register read with write-back bypass, load-use detection
    always_comb begin
        id_ctrl    = decode(ifid_q.instr);
        id_rs1     = ifid_q.instr[19:15];
        id_rs2     = ifid_q.instr[24:20];
        id_rs1_val = Regs[id_rs1];
        id_rs2_val = Regs[id_rs2];
        if (id_rs1 == 5'd0)
            id_rs1_val = 32'd0;
        else if (memwb_q.reg_we && memwb_q.rd == id_rs1)
            id_rs1_val = memwb_q.wb_val;
        if (id_rs2 == 5'd0)
            id_rs2_val = 32'd0;
        else if (memwb_q.reg_we && memwb_q.rd == id_rs2)
            id_rs2_val = memwb_q.wb_val;
        stall = idex_q.ctrl.mem_re && idex_q.rd != 5'd0 &&
                ((id_ctrl.use_rs1 && idex_q.rd == id_rs1) ||
                 (id_ctrl.use_rs2 && idex_q.rd == id_rs2));
    end

    // EX operand forwarding: EX/MEM wins over MEM/WB, x0 never forwarded
    always_comb begin
        ex_a = idex_q.rs1_val;
        if (exmem_q.reg_we && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs1)
            ex_a = exmem_q.alu_res;
        else if (memwb_q.reg_we && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs1)
            ex_a = memwb_q.wb_val;
        ex_b = idex_q.rs2_val;
        if (exmem_q.reg_we && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs2)
            ex_b = exmem_q.alu_res;
        else if (memwb_q.reg_we && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs2)
            ex_b = memwb_q.wb_val;
        ex_b_alu = idex_q.ctrl.use_imm ? idex_q.ctrl.imm : ex_b;
    end

    riscv_alu u_alu (
        .a    (ex_a),
        .b    (ex_b_alu),
        .fn   (idex_q.ctrl.alu_fn),
        .y    (ex_res),
        .zero (ex_zero)
    );

    assign ex_target   = idex_q.pc + idex_q.ctrl.imm;
    assign take_branch = idex_q.ctrl.branch && ex_zero;

    assign mem_rdata  = DMemory[exmem_q.alu_res[DAW+1:2]];
    assign mem_wb_val = exmem_q.mem_re ? mem_rdata : exmem_q.alu_res;

    always_comb begin
        pc_d         = pc_q + 32'd4;
        ifid_d       = IFID_RST;
        ifid_d.pc    = pc_q;
        ifid_d.instr = IMemory[pc_q[IAW+1:2]];

        idex_d         = IDEX_RST;
        idex_d.pc      = ifid_q.pc;
        idex_d.instr   = ifid_q.instr;
        idex_d.rs1_val = id_rs1_val;
        idex_d.rs2_val = id_rs2_val;
        idex_d.rs1     = id_rs1;
        idex_d.rs2     = id_rs2;
        idex_d.rd      = ifid_q.instr[11:7];
        idex_d.ctrl    = id_ctrl;

        if (stall) begin
            pc_d   = pc_q;
            ifid_d = ifid_q;
            idex_d = IDEX_RST;
        end
        // A taken branch overrides any stall: both younger slots are squashed.
        if (take_branch) begin
            pc_d   = ex_target;
            ifid_d = IFID_RST;
            idex_d = IDEX_RST;
        end

        exmem_d           = EXMEM_RST;
        exmem_d.instr     = idex_q.instr;
        exmem_d.alu_res   = ex_res;
        exmem_d.store_val = ex_b;
        exmem_d.rd        = idex_q.rd;
        exmem_d.reg_we    = idex_q.ctrl.reg_we;
        exmem_d.mem_re    = idex_q.ctrl.mem_re;
        exmem_d.mem_we    = idex_q.ctrl.mem_we;

        memwb_d        = MEMWB_RST;
        memwb_d.instr  = exmem_q.instr;
        memwb_d.wb_val = mem_wb_val;
        memwb_d.rd     = exmem_q.rd;
        memwb_d.reg_we = exmem_q.reg_we;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q    <= 32'd0;
            ifid_q  <= IFID_RST;
            idex_q  <= IDEX_RST;
            exmem_q <= EXMEM_RST;
            memwb_q <= MEMWB_RST;
        end else begin
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    // Write enables come from async-cleared stage registers, so nothing writes during reset.
    always_ff @(posedge clock) begin
        if (memwb_q.reg_we && memwb_q.rd != 5'd0)
            Regs[memwb_q.rd] <= memwb_q.wb_val;
        if (exmem_q.mem_we)
            DMemory[exmem_q.alu_res[DAW+1:2]] <= exmem_q.store_val;
    end

    assign unused_bits = ^{memwb_q.instr, idex_q.ctrl.use_rs1, idex_q.ctrl.use_rs2, NOP};

endmodule

// File: tb/tb_riscv_cpu.sv
// Directed bench for riscv_cpu: table of small programs with expected register
// contents, plus timed sequences for latency, load-use stall and mid-run reset.
module tb_riscv_cpu;
    import riscv_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] p [8];
        logic [4:0]  r [3];
        logic [31:0] e [3];
    } vec_t;

    localparam logic [31:0] N = NOP_INSTR;

    logic clock  = 1'b0;
    logic reset  = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs [9];

    riscv_cpu #(.IMEM_WORDS(1024), .DMEM_WORDS(1024)) dut (
        .clock (clock),
        .reset (reset)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    // Holds reset, loads program v with zeroed Regs/DMemory, releases on a falling edge.
    task automatic load(input int v);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 1024; i++) begin
            dut.IMemory[i] = N;
            dut.DMemory[i] = 32'd0;
        end
        for (int i = 0; i < 32; i++) dut.Regs[i] = 32'd0;
        for (int i = 0; i < 8; i++) dut.IMemory[i] = vecs[v].p[i];
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{name: "basic",
                    p: '{32'h00500093, 32'h00500113, 32'h002081B3, N, N, N, N, N},
                    r: '{5'd1, 5'd2, 5'd3}, e: '{32'd5, 32'd5, 32'd10}};
        vecs[1] = '{name: "x0_hard",
                    p: '{32'h00700013, 32'h00000233, N, N, N, N, N, N},
                    r: '{5'd0, 5'd4, 5'd0}, e: '{32'd0, 32'd0, 32'd0}};
        vecs[2] = '{name: "load_use",
                    p: '{32'h00C00093, 32'h00102023, 32'h00002103, 32'h002101B3, N, N, N, N},
                    r: '{5'd1, 5'd2, 5'd3}, e: '{32'd12, 32'd12, 32'd24}};
        vecs[3] = '{name: "beq_taken",
                    p: '{32'h00100093, 32'h00000463, 32'h00900293, 32'h00300313, N, N, N, N},
                    r: '{5'd1, 5'd5, 5'd6}, e: '{32'd1, 32'd0, 32'd3}};
        vecs[4] = '{name: "beq_not",
                    p: '{32'h00100093, 32'h00008463, 32'h00900293, 32'h00300313, N, N, N, N},
                    r: '{5'd1, 5'd5, 5'd6}, e: '{32'd1, 32'd9, 32'd3}};
        vecs[5] = '{name: "wrap",
                    p: '{32'hFFF00093, 32'h00108113, N, N, N, N, N, N},
                    r: '{5'd1, 5'd2, 5'd0}, e: '{32'hFFFFFFFF, 32'd0, 32'd0}};
        vecs[6] = '{name: "alu",
                    p: '{32'h00C00093, 32'h00A00113, 32'h402081B3, 32'h0020F233,
                         32'h0020E2B3, 32'h0020C3B3, N, N},
                    r: '{5'd3, 5'd4, 5'd5}, e: '{32'd2, 32'd8, 32'd14}};
        vecs[7] = '{name: "unsupported",
                    p: '{32'h00C00093, 32'h00A00113, 32'h402081B3, 32'h0020F233,
                         32'h0020E2B3, 32'h0020C3B3, N, N},
                    r: '{5'd7, 5'd1, 5'd2}, e: '{32'd0, 32'd12, 32'd10}};
        vecs[8] = '{name: "chain",
                    p: '{32'h00108093, 32'h00108093, 32'h00108093, 32'h00108093, N, N, N, N},
                    r: '{5'd1, 5'd0, 5'd2}, e: '{32'd4, 32'd0, 32'd0}};

        // Power-up state without any reset pulse
        #1;
        check("powerup_pc", dut.pc_q, 32'd0);
        check("powerup_ifid", dut.ifid_q.instr, N);
        check("powerup_idex", dut.idex_q.instr, N);

        foreach (vecs[v]) begin
            load(v);
            repeat (14) @(posedge clock);
            #1;
            for (int j = 0; j < 3; j++)
                check($sformatf("%s x%0d", vecs[v].name, vecs[v].r[j]),
                      dut.Regs[vecs[v].r[j]], vecs[v].e[j]);
        end

        // Commit latency: IMemory[k] writes its register at edge k+5
        load(0);
        repeat (4) @(posedge clock);
        #1 check("lat_x1_edge4", dut.Regs[1], 32'd0);
        @(posedge clock);
        #1 check("lat_x1_edge5", dut.Regs[1], 32'd5);
        @(posedge clock);
        #1 check("lat_x2_edge6", dut.Regs[2], 32'd5);
        @(posedge clock);
        #1 check("lat_x3_edge7", dut.Regs[3], 32'd10);

        // Load-use: dependent ADD commits one edge late (edge 9 instead of 8)
        load(2);
        repeat (7) @(posedge clock);
        #1 check("lu_x2_edge7", dut.Regs[2], 32'd12);
        @(posedge clock);
        #1 check("lu_x3_edge8", dut.Regs[3], 32'd0);
        @(posedge clock);
        #1 check("lu_x3_edge9", dut.Regs[3], 32'd24);
        check("lu_dmem0", dut.DMemory[0], 32'd12);

        // Mid-run reset: async clear, no writes while high, clean restart
        load(8);
        repeat (6) @(posedge clock);
        #1 check("rst_x1_before", dut.Regs[1], 32'd2);
        #3 reset = 1'b1;
        #1;
        check("rst_pc_async", dut.pc_q, 32'd0);
        check("rst_ifid_nop", dut.ifid_q.instr, N);
        check("rst_idex_nop", dut.idex_q.instr, N);
        repeat (3) @(posedge clock);
        #1 check("rst_x1_held", dut.Regs[1], 32'd2);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1 check("rst_x1_restart_e4", dut.Regs[1], 32'd2);
        @(posedge clock);
        #1 check("rst_x1_restart_e5", dut.Regs[1], 32'd3);
        repeat (10) @(posedge clock);
        #1 check("rst_x1_final", dut.Regs[1], 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_cpu.md
RISCV_CPU -- requirements
Module: riscv_cpu

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter IMEM_WORDS, default 1024: instruction memory depth in 32-bit words.
REQ-003 Parameter DMEM_WORDS, default 1024: data memory depth in 32-bit words.
REQ-004 Port: clock  input  1  rising-edge clock for all state.
REQ-005 Port: reset  input  1  asynchronous active-high reset.
REQ-006 There SHALL be no other ports.
- Memories and register file are internal.
- Benches load and inspect them hierarchically.
REQ-007 Internal names SHALL be fixed for hierarchical bench access:
- IMemory: array of 32-bit words.
- DMemory: array of 32-bit words.
- Regs: 32 x 32-bit register file.
- NOP: 32-bit constant 32'h00000013 (ADDI x0,x0,0).

Function
REQ-008 Architecture SHALL be a classic 5-stage in-order pipeline: IF, ID, EX, MEM, WB.
REQ-009 Supported RV32I subset SHALL be:
- ADD, SUB, AND, OR (opcode 0110011).
- ADDI (0010011).
- LW (0000011).
- SW (0100011).
- BEQ (1100011).
- Any other encoding executes as NOP.
REQ-010 IF SHALL fetch IMemory[PC[31:2]]; PC SHALL advance by 4 each non-stalled cycle; PC wraps modulo memory size on index.
REQ-011 Immediates SHALL be sign-extended per RV32I I/S/B formats; arithmetic is 32-bit, wrap-around, no overflow trap.
REQ-012 Data memory SHALL be word-addressed by ALU result [31:2]:
- LW reads combinationally in MEM.
- SW writes at the clock edge in MEM.
REQ-013 Register write SHALL occur at the clock edge ending WB; writes to x0 are suppressed, so Regs[0] always reads 0.
REQ-014 ID register reads SHALL bypass a same-cycle WB write to the same non-zero register.
REQ-015 EX SHALL forward operands from EX/MEM (priority) and MEM/WB for ALU results and load data; never from x0.
REQ-016 Load-use hazard SHALL stall PC and IF/ID one cycle and insert a NOP bubble into ID/EX; no other stalls exist.
REQ-017 BEQ SHALL be predicted not-taken and resolved in EX:
- Taken: PC <= branch PC + B-immediate.
- IF/ID and ID/EX flushed to NOP (2-cycle penalty).
REQ-018 Latency: with no hazards, the instruction at IMemory[k] SHALL commit its register write at rising edge k+5 after reset release.
- k counts from 0.
- Edge 1 is the first edge.
REQ-019 Dependent back-to-back ALU instructions SHALL execute with zero stall cycles.

Reset
REQ-020 Asserting reset SHALL immediately set PC to 0 and every pipeline instruction register to NOP, independent of clock.
REQ-021 All other pipeline registers SHALL reset to 0.
REQ-022 Regs, IMemory and DMemory SHALL NOT be cleared by reset.
REQ-023 PC and pipeline registers SHALL also power up (simulation time 0) at their reset values, so execution proceeds correctly if reset is never asserted.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight instructions; no register or memory write occurs while reset is high.

Structure
REQ-025 Opcode constants, the NOP encoding and the ALU function encodings SHALL live in a shared package riscv_pkg.
REQ-026 One sub-module is natural: riscv_alu (combinational, operands a and b, function select, 32-bit result, zero flag).

Verification
REQ-027 Bench SHALL cover the following directed scenarios:
- IMemory[0..2] = 00500093, 00500113, 002081B3; rest NOP; Regs zeroed; run 100 ns at 10 ns period -> x0=0, x1=5, x2=5, x3=10.
- ADDI x0,x0,7 followed by ADD x4,x0,x0 -> Regs[0]=0 and x4=0.
- ADDI x1,x0,12; SW x1,0(x0); LW x2,0(x0); ADD x3,x2,x2 (load-use) -> DMemory[0]=12, x3=24, exactly one stall cycle.
- ADDI x1,x0,1; BEQ x0,x0,+8; ADDI x5,x0,9; ADDI x6,x0,3 -> x5=0 (flushed), x6=3.
- Reset pulse asserted mid-run -> PC=0 immediately; no writes while high; program restarts from IMemory[0].
- ADDI x1,x0,-1; ADDI x2,x1,1 -> x1=FFFFFFFF, x2=0 (wrap-around).
